vram_port_arbiter: RTL and testbench

//  Shares the single host-side port (port A) of the video memory between two bus masters.
//  m0 is the CPU/MMIO path; m1 is the fill/copy engine.

---
 rtl/vram_port_arbiter.sv | 97 +++++++++
 tb/tb_vram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Two-master arbiter for the video memory host port (port A).
// Round-robin with a per-owner burst limit; read data is routed back one cycle after issue.
module vram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk_a,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_ack,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_ack,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_write,
  input  logic [DATA_WIDTH-1:0]   mem_read,
  output logic                    grant_id
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_prio;
  logic             r_last;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [1:0]       r_rd_pend;

  logic             w_valid;
  logic             w_sel;
  logic [CNT_W-1:0] w_cnt_new;
  logic             w_sel_read;

  // Contention goes to prio; otherwise the lone requester wins (m0 by default when idle).
  assign w_valid = m0_req | m1_req;
  assign w_sel   = (m0_req && m1_req) ? r_prio : m1_req;

  always_comb begin
    w_cnt_new = CNT_ONE;
    if (w_sel == r_last) begin
      if (r_burst_cnt >= CNT_MAX) w_cnt_new = CNT_MAX;
      else                        w_cnt_new = r_burst_cnt + CNT_ONE;
    end
  end

  assign w_sel_read = w_sel ? (m1_we == '0) : (m0_we == '0);

  assign mem_en    = w_valid;
  assign mem_we    = !w_valid ? '0 : (w_sel ? m1_we    : m0_we);
  assign mem_addr  = !w_valid ? '0 : (w_sel ? m1_addr  : m0_addr);
  assign mem_write = !w_valid ? '0 : (w_sel ? m1_wdata : m0_wdata);
  assign grant_id  = w_valid & w_sel;
  assign m0_ack    = w_valid & ~w_sel;
  assign m1_ack    = w_valid &  w_sel;

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
      r_rd_pend   <= 2'b00;
    end else begin
      r_rd_pend[0] <= w_valid && !w_sel && w_sel_read;
      r_rd_pend[1] <= w_valid &&  w_sel && w_sel_read;
      if (w_valid) begin
        r_last <= w_sel;
        // Hitting the limit hands priority to the other master and restarts the count.
        if (w_cnt_new == CNT_MAX) begin
          r_prio      <= ~w_sel;
          r_burst_cnt <= '0;
        end else begin
          r_prio      <= w_sel;
          r_burst_cnt <= w_cnt_new;
        end
      end
    end
  end

  assign m0_rvalid = r_rd_pend[0];
  assign m1_rvalid = r_rd_pend[1];
  assign m0_rdata  = r_rd_pend[0] ? mem_read : '0;
  assign m1_rdata  = r_rd_pend[1] ? mem_read : '0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: grant order, burst fairness, read return and reset.
module tb_vram_port_arbiter;

  logic        clk_a = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write, mem_read;
  logic        grant_id;

  int tests_run = 0;
  int tests_failed = 0;

  int unsigned exp_owner_q[$];
  logic [31:0] exp_data_q[$];

  vram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk_a(clk_a), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_read(mem_read), .grant_id(grant_id)
  );

  always #5 clk_a = ~clk_a;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk_a);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 4'h0; m0_addr = 16'h0; m0_wdata = 32'h0;
    m1_req = 0; m1_we = 4'h0; m1_addr = 16'h0; m1_wdata = 32'h0;
    mem_read = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_a);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1; m1_req = 1; m0_we = 4'hF; m1_we = 4'hF;
    rst = 1'b1;
    @(negedge clk_a);
    tests_run++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rvalid: got m0=%b m1=%b, want 0 0", m0_rvalid, m1_rvalid);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk_a);
    tests_run++;
    if (grant_id !== 1'b0 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got gid=%b a0=%b a1=%b, want 0 1 0", grant_id, m0_ack, m1_ack);
    end
    $display("[TB] reset: first grant gid=%b", grant_id);
    next_cycle();
  endtask

  task automatic test_round_robin();
    idle_inputs();
    m0_req = 1; m1_req = 1; m0_we = 4'hF; m1_we = 4'hF;
    do_reset();
    for (int k = 0; k < 12; k++) exp_owner_q.push_back(((k / 4) % 2 == 0) ? 0 : 1);
    for (int k = 0; k < 12; k++) begin
      int unsigned exp_o;
      exp_o = exp_owner_q.pop_front();
      @(negedge clk_a);
      tests_run++;
      if (grant_id !== exp_o[0] || m0_ack !== ~exp_o[0] || m1_ack !== exp_o[0] ||
          m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL round_robin[%0d]: got gid=%b a0=%b a1=%b rv=%b%b, want gid=%0d no rvalid",
                 k, grant_id, m0_ack, m1_ack, m0_rvalid, m1_rvalid, exp_o);
      end
      $display("[TB] round_robin cycle %0d grant=%b", k, grant_id);
      next_cycle();
    end
  endtask

  task automatic test_lone_m1();
    idle_inputs();
    m1_req = 1; m1_we = 4'hF;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_a);
      tests_run++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || grant_id !== 1'b1) begin
        tests_failed++;
        $display("FAIL lone_m1[%0d]: got a1=%b a0=%b gid=%b, want 1 0 1", k, m1_ack, m0_ack, grant_id);
      end
      $display("[TB] lone_m1 cycle %0d ack=%b", k, m1_ack);
      next_cycle();
    end
    // Burst count is 2 after ten lone grants, so m1 keeps two more before yielding.
    m0_req = 1; m0_we = 4'hF;
    exp_owner_q = '{1, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 7; k++) begin
      int unsigned exp_o;
      exp_o = exp_owner_q.pop_front();
      @(negedge clk_a);
      tests_run++;
      if (grant_id !== exp_o[0] || m1_ack !== exp_o[0] || m0_ack !== ~exp_o[0]) begin
        tests_failed++;
        $display("FAIL lone_then_both[%0d]: got gid=%b a0=%b a1=%b, want gid=%0d",
                 k, grant_id, m0_ack, m1_ack, exp_o);
      end
      $display("[TB] lone_then_both cycle %0d grant=%b", k, grant_id);
      next_cycle();
    end
  endtask

  task automatic test_read_return();
    idle_inputs();
    do_reset();
    m0_req = 1; m0_we = 4'h0; m0_addr = 16'h0010;
    @(negedge clk_a);
    tests_run++;
    if (m0_ack !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0 || mem_addr !== 16'h0010) begin
      tests_failed++;
      $display("FAIL read_issue: got ack=%b en=%b we=%h addr=%h, want 1 1 0 0010", m0_ack, mem_en, mem_we, mem_addr);
    end
    exp_data_q.push_back(32'hDEADBEEF);
    next_cycle();
    m0_req = 0;
    mem_read = 32'hDEADBEEF;
    @(negedge clk_a);
    begin
      logic [31:0] exp_d;
      exp_d = exp_data_q.pop_front();
      tests_run++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== exp_d || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL read_return: got rv0=%b rd0=%h rv1=%b rd1=%h, want 1 %h 0 0",
                 m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, exp_d);
      end
      $display("[TB] read_return m0_rdata=%h", m0_rdata);
    end
    next_cycle();
    @(negedge clk_a);
    tests_run++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL read_single_pulse: got rv0=%b rd0=%h, want 0 0", m0_rvalid, m0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    m0_req = 1; m1_req = 1; m0_we = 4'h0; m1_we = 4'h0;
    m0_addr = 16'h0100; m1_addr = 16'h0200;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      logic [31:0] rd_val;
      int unsigned exp_g;
      rd_val = $urandom;
      mem_read = rd_val;
      exp_g = ((k / 4) % 2 == 0) ? 0 : 1;
      @(negedge clk_a);
      if (k > 0) begin
        int unsigned prev_o;
        prev_o = exp_owner_q.pop_front();
        tests_run++;
        if ((prev_o == 0 && (m0_rvalid !== 1'b1 || m0_rdata !== rd_val || m1_rvalid !== 1'b0)) ||
            (prev_o == 1 && (m1_rvalid !== 1'b1 || m1_rdata !== rd_val || m0_rvalid !== 1'b0))) begin
          tests_failed++;
          $display("FAIL b2b_return[%0d]: got rv0=%b rd0=%h rv1=%b rd1=%h, want owner %0d data %h",
                   k, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, prev_o, rd_val);
        end
      end
      tests_run++;
      if (grant_id !== exp_g[0]) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d]: got gid=%b, want %0d", k, grant_id, exp_g);
      end
      exp_owner_q.push_back(exp_g);
      $display("[TB] back_to_back cycle %0d grant=%b rv=%b%b", k, grant_id, m1_rvalid, m0_rvalid);
      next_cycle();
    end
    exp_owner_q.delete();
  endtask

  task automatic test_partial_write();
    idle_inputs();
    do_reset();
    m1_req = 1; m1_we = 4'b0011; m1_addr = 16'h8000; m1_wdata = 32'h1234_5678;
    @(negedge clk_a);
    tests_run++;
    if (mem_en !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 16'h8000 ||
        mem_write !== 32'h1234_5678 || m1_ack !== 1'b1 || grant_id !== 1'b1) begin
      tests_failed++;
      $display("FAIL partial_write: got en=%b we=%b addr=%h wd=%h ack=%b gid=%b, want 1 0011 8000 12345678 1 1",
               mem_en, mem_we, mem_addr, mem_write, m1_ack, grant_id);
    end
    $display("[TB] partial_write we=%b addr=%h", mem_we, mem_addr);
    next_cycle();
    m1_req = 0;
    mem_read = 32'hA5A5_A5A5;
    @(negedge clk_a);
    tests_run++;
    if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL write_no_rvalid: got rv1=%b rv0=%b rd1=%h, want 0 0 0", m1_rvalid, m0_rvalid, m1_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_drop();
    idle_inputs();
    do_reset();
    m0_req = 1; m0_we = 4'h0; m0_addr = 16'h0040;
    @(negedge clk_a);
    tests_run++;
    if (m0_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_ack: got %b, want 1", m0_ack);
    end
    next_cycle();
    rst = 1'b1;
    idle_inputs();
    mem_read = 32'hCAFE_F00D;
    @(negedge clk_a);
    tests_run++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0 ||
        mem_addr !== 16'h0 || mem_write !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_drop: got rv0=%b rv1=%b en=%b we=%h addr=%h wd=%h, want all 0",
               m0_rvalid, m1_rvalid, mem_en, mem_we, mem_addr, mem_write);
    end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_a);
      tests_run++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL post_reset_rvalid[%0d]: got rv0=%b rd0=%h, want 0 0", k, m0_rvalid, m0_rdata);
      end
      next_cycle();
    end
    $display("[TB] reset_drop done");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_round_robin();
    test_lone_m1();
    test_read_return();
    test_back_to_back();
    test_partial_write();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
